// File: rtl/action_ram_ctrl.sv
// rtl/action_ram_ctrl.sv - action table RAM with registered read and clear sequencer (option: ACTION_RAM_BYPASS_EN)
module action_ram_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] d_in,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              clear_request,
  output logic [DATA_W-1:0] d_out,
  output logic              d_out_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clear_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_range;
  logic              rd_in_range;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] rd_word;

  assign wr_in_range = {1'b0, write_address} < DEPTH_V;
  assign rd_in_range = {1'b0, read_address} < DEPTH_V;
  // user accesses only count in READY and lose to a clear request on the same edge
  assign accept      = reset_n && (state == READY) && !clear_request;

  // single write port shared between the clear sequencer and user writes; idle during reset
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = clear_cnt;
    mem_data = INIT_VAL;
    if (reset_n) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (accept && write_enable && wr_in_range) begin
        mem_we   = 1'b1;
        mem_addr = write_address;
        mem_data = d_in;
      end
    end
  end

  // word returned by a read this edge; out-of-range reads yield zero
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
`ifdef ACTION_RAM_BYPASS_EN
      if (write_enable && wr_in_range && (write_address == read_address))
        rd_word = d_in;
      else
        rd_word = mem[read_address];
`else
      rd_word = mem[read_address];
`endif
    end
  end

  // storage array, kept free of reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (mem_we)
      mem[mem_addr] <= mem_data;
  end

  // clear/ready sequencer with registered read data, valid and busy
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= CLEAR;
      clear_cnt   <= '0;
      d_out       <= '0;
      d_out_valid <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          d_out_valid <= 1'b0;
          if (clear_cnt == LAST_ADDR) begin
            state     <= READY;
            clear_cnt <= '0;
            busy      <= 1'b0;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
            busy      <= 1'b1;
          end
        end
        READY: begin
          if (clear_request) begin
            state       <= CLEAR;
            clear_cnt   <= '0;
            busy        <= 1'b1;
            d_out_valid <= 1'b0;
          end else if (read_enable) begin
            d_out       <= rd_word;
            d_out_valid <= 1'b1;
          end else begin
            d_out_valid <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_action_ram_ctrl.sv
// tb/tb_action_ram_ctrl.sv - directed bench with behavioural model for action_ram_ctrl
`timescale 1ns/1ps
module tb_action_ram_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        write_enable;
  logic [7:0]  write_address;
  logic [15:0] d_in;
  logic        read_enable;
  logic [7:0]  read_address;
  logic        clear_request;
  logic [15:0] dout0, dout1;
  logic        valid0, valid1, busy0, busy1;

  int vectors = 0;
  int miscompares = 0;

`ifdef ACTION_RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam logic [15:0] INIT = 16'hA5A5;

  always #5 clock = ~clock;

  action_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .INIT_VAL(INIT)) dut0 (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .write_address(write_address), .d_in(d_in), .read_enable(read_enable),
    .read_address(read_address), .clear_request(clear_request),
    .d_out(dout0), .d_out_valid(valid0), .busy(busy0));

  action_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .INIT_VAL(INIT)) dut1 (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .write_address(write_address), .d_in(d_in), .read_enable(read_enable),
    .read_address(read_address), .clear_request(clear_request),
    .d_out(dout1), .d_out_valid(valid1), .busy(busy1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: word arrays plus a count of clear writes still owed
  logic [15:0] em [2][256];
  int          rem [2];
  logic [15:0] ed [2];
  logic        ev [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      rem[k] = depth_of(k);
      ed[k]  = 16'h0;
      ev[k]  = 1'b0;
      for (int a = 0; a < 256; a++) em[k][a] = 16'h0;
    end
  end

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      int d;
      d = depth_of(k);
      if (!reset_n) begin
        rem[k] = d;
        ed[k]  = 16'h0;
        ev[k]  = 1'b0;
      end else if (rem[k] > 0) begin
        em[k][d - rem[k]] = INIT;
        rem[k] = rem[k] - 1;
        ev[k]  = 1'b0;
      end else if (clear_request) begin
        rem[k] = d;
        ev[k]  = 1'b0;
      end else begin
        if (read_enable) begin
          ev[k] = 1'b1;
          if (int'(read_address) >= d)
            ed[k] = 16'h0;
          else if (BYPASS && write_enable && write_address == read_address)
            ed[k] = d_in;
          else
            ed[k] = em[k][read_address];
        end else begin
          ev[k] = 1'b0;
        end
        if (write_enable && int'(write_address) < d)
          em[k][write_address] = d_in;
      end
    end
    #1;
    chk("busy0",  {31'b0, busy0},  {31'b0, rem[0] > 0});
    chk("busy1",  {31'b0, busy1},  {31'b0, rem[1] > 0});
    chk("valid0", {31'b0, valid0}, {31'b0, ev[0]});
    chk("valid1", {31'b0, valid1}, {31'b0, ev[1]});
    chk("dout0",  {16'b0, dout0},  {16'b0, ed[0]});
    chk("dout1",  {16'b0, dout1},  {16'b0, ed[1]});
  end

  // drive one edge worth of inputs from a falling edge, return at the next falling edge
  task automatic cyc(input logic we, input logic [7:0] wa, input logic [15:0] din,
                     input logic re, input logic [7:0] ra, input logic clr);
    write_enable  = we;
    write_address = wa;
    d_in          = din;
    read_enable   = re;
    read_address  = ra;
    clear_request = clr;
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h0, 16'h0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic count_busy(output int n0, output int n1);
    int n;
    n = 0; n0 = 0; n1 = 0;
    while ((busy0 || busy1) && n < 400) begin
      n++;
      if (busy0) n0++;
      if (busy1) n1++;
      idle();
    end
  endtask

  initial begin
    int n0, n1;
    reset_n = 1'b0;
    write_enable = 1'b0; write_address = 8'h0; d_in = 16'h0;
    read_enable = 1'b0; read_address = 8'h0; clear_request = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    count_busy(n0, n1);
    chk("clear_len256", n0, 256);
    chk("clear_len200", n1, 200);

    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'h00, 1'b0);
    chk("init_rd00", {15'b0, valid0, dout0}, {15'b0, 1'b1, 16'hA5A5});
    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'h7F, 1'b0);
    chk("init_rd7f", {15'b0, valid0, dout0}, {15'b0, 1'b1, 16'hA5A5});
    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'hFF, 1'b0);
    chk("init_rdff", {15'b0, valid0, dout0}, {15'b0, 1'b1, 16'hA5A5});
    chk("oor_rdff",  {15'b0, valid1, dout1}, {15'b0, 1'b1, 16'h0000});

    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h20 + 8'(i), 16'(i + 2), 1'b0, 8'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'h20 + 8'(i), 1'b0);
      chk("burst_rd", {15'b0, valid0, dout0}, {15'b0, 1'b1, 16'(i + 2)});
    end
    idle();
    chk("burst_end", {31'b0, valid0}, 32'd0);

    cyc(1'b1, 8'h30, 16'h1234, 1'b0, 8'h0, 1'b0);
    cyc(1'b1, 8'h30, 16'h5678, 1'b1, 8'h30, 1'b0);
    chk("collide", {16'b0, dout0}, BYPASS ? 32'h5678 : 32'h1234);
    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'h30, 1'b0);
    chk("collide_after", {16'b0, dout0}, 32'h5678);

    cyc(1'b1, 8'h40, 16'd9, 1'b0, 8'h0, 1'b0);
    cyc(1'b1, 8'h41, 16'h0077, 1'b1, 8'h40, 1'b1);
    chk("clr_busy", {31'b0, busy0}, 32'd1);
    cyc(1'b1, 8'h41, 16'h0077, 1'b0, 8'h0, 1'b0);
    count_busy(n0, n1);
    chk("clr_len256", n0, 255);
    chk("clr_done", {30'b0, busy0, busy1}, 32'd0);
    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'h40, 1'b0);
    chk("clr_rd40", {16'b0, dout0}, {16'b0, INIT});
    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'h41, 1'b0);
    chk("clr_rd41", {16'b0, dout0}, {16'b0, INIT});

    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'h41, 1'b1);
    repeat (100) idle();
    reset_n = 1'b0;
    idle();
    chk("rst_mid", {14'b0, busy0, valid0, dout0}, {14'b0, 1'b1, 1'b0, 16'h0});
    reset_n = 1'b1;
    count_busy(n0, n1);
    chk("rst_len256", n0, 256);
    chk("rst_len200", n1, 200);

    cyc(1'b1, 8'hF0, 16'hFFFF, 1'b0, 8'h0, 1'b0);
    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'hF0, 1'b0);
    chk("oor_rdf0",  {15'b0, valid1, dout1}, {15'b0, 1'b1, 16'h0000});
    chk("inr_rdf0",  {16'b0, dout0}, 32'hFFFF);
    cyc(1'b1, 8'd199, 16'hBEEF, 1'b0, 8'h0, 1'b0);
    cyc(1'b0, 8'h0, 16'h0, 1'b1, 8'd199, 1'b0);
    chk("last_rd199", {15'b0, valid1, dout1}, {15'b0, 1'b1, 16'hBEEF});
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/action_ram_ctrl.md
# action_ram_ctrl

Parametrised successor to the tic-tac-toe action RAM: a simple dual-port synchronous memory (one write port, one read port) with configurable data width and depth, a registered read with a valid strobe, and a hardware clear sequencer. After reset or on request, the sequencer fills every word with a programmable value. The block holds the move/action table for the game controller and accepts accesses only when not busy.

## Interface
Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of words (≤ 2**ADDR_W)
- INIT_VAL, 0, value written to every word during clear (DATA_W bits)

Ports:
- clock  input  1  single clock; all logic is on the rising edge
- reset_n  input  1  reset, synchronous and active-low
- write_enable  input  1  write strobe
- write_address  input  ADDR_W  write address
- d_in  input  DATA_W  write data
- read_enable  input  1  read strobe
- read_address  input  ADDR_W  read address
- clear_request  input  1  one-cycle pulse that starts a full clear
- d_out  output  DATA_W  registered read data
- d_out_valid  output  1  d_out holds the result of the read issued on the previous edge
- busy  output  1  high while clearing; accesses are ignored

## Operation
- FSM with two states: CLEAR and READY.
- Reset (reset_n low at an edge):
  - state goes to CLEAR and the clear counter goes to 0.
  - d_out goes to 0, d_out_valid to 0, busy to 1.
  - Memory contents are not touched during reset itself.
- CLEAR state:
  - At each edge, INIT_VAL is written to address clear_cnt, then clear_cnt increments.
  - When clear_cnt = DEPTH-1 is written, the FSM moves to READY.
  - In CLEAR: busy=1, write_enable/read_enable/clear_request are ignored, d_out_valid=0, d_out holds its value.
- READY state:
  - busy=0.
  - write_enable=1 writes d_in to mem[write_address].
  - read_enable=1 loads d_out with mem[read_address] at the edge; d_out_valid is 1 for the following cycle only.
  - read_enable=0 sets d_out_valid to 0; d_out holds its value.
- clear_request in READY moves the FSM to CLEAR at the next edge and resets clear_cnt to 0.
  - A write or read on that same edge is ignored.
- Out-of-range addresses (address ≥ DEPTH):
  - writes are dropped.
  - reads return 0 with d_out_valid=1.
- Read/write to the same address on the same edge: behaviour is set by the configuration macro below.
- Reset mid-clear restarts the clear from address 0.

## Timing
- Read latency is 1 cycle: address sampled at edge N, data and d_out_valid visible after edge N, valid until edge N+1.
- Write takes effect at the edge; a read of the same address at edge N+1 or later returns the new data.
- Clear duration is DEPTH edges after reset_n is sampled high, or after the clear_request edge. busy falls after the DEPTH-th clear edge.
- Back-to-back reads every cycle give continuous d_out_valid=1.

## Configuration
- ACTION_RAM_BYPASS_EN
  - Defined: write-first. A same-address read and write on one edge returns d_in on d_out.
  - Undefined: read-first. The same case returns the old word; the write still lands.
- The macro affects only this collision case. All other behaviour is identical.

## Test plan
- Reset then clear, with INIT_VAL=16'hA5A5 and DEPTH=256:
  - hold reset_n low 2 cycles, release.
  - busy stays high exactly 256 cycles.
  - reads of addresses 0x00, 0x7F and 0xFF then return 16'hA5A5 with valid.
- Writes then reads in READY:
  - write addresses 0x20–0x25 with data 2..7.
  - read 0x20–0x25 back-to-back; d_out is 2..7 with d_out_valid held high for 6 cycles, one cycle after each address.
- Collision: write 0x30←16'h1234, then same edge write 0x30←16'h5678 with read 0x30.
  - With ACTION_RAM_BYPASS_EN: d_out=16'h5678.
  - Without it: d_out=16'h1234.
  - A later read returns 16'h5678 in both builds.
- Clear request:
  - write 0x40←9, pulse clear_request.
  - busy rises at the next edge.
  - a write to 0x41 during CLEAR is ignored.
  - after busy falls, 0x40 and 0x41 read INIT_VAL.
- Reset mid-clear:
  - assert reset_n low at clear_cnt=100 for 1 cycle.
  - busy stays high for a further full 256 cycles.
  - d_out=0 and d_out_valid=0 during reset.
- Out of range, with DEPTH=200:
  - write 0xF0←16'hFFFF is dropped.
  - read 0xF0 returns 0 with valid.
  - address 199 is still writable and readable.
